rng_scheduler: RTL and testbench

Time-shared front end for the free-running 10-bit LFSR random source. Several game consumers (enemy-fire timer, dive-attack selector, spawn column picker, star field) request a random number bounded to their own range. The scheduler grants one requester at a time in round-robin order and samples the LFSR. It reduces the sample modulo that requester's limit with a fixed-latency bit-serial restoring remainder, then returns the result with a one-cycle ack. It also flags an LFSR that has stopped advancing.

---
 rtl/rng_scheduler_if.sv | 24 ++
 rtl/rng_scheduler.sv | 111 +++++++++++
 tb/tb_rng_scheduler.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rng_scheduler_if.sv
// Bundle of request, limit, LFSR and result signals shared by the RNG
// scheduler and its consumers.
interface rng_scheduler_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 10
);
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] limit;
   logic [WIDTH-1:0]       lfsr_value;
   logic [N_REQ-1:0]       ack;
   logic [WIDTH-1:0]       rng_out;
   logic                   busy;
   logic                   lfsr_stuck;

   modport master (
      output req, limit, lfsr_value,
      input  ack, rng_out, busy, lfsr_stuck
   );

   modport slave (
      input  req, limit, lfsr_value,
      output ack, rng_out, busy, lfsr_stuck
   );
endinterface

// File: rtl/rng_scheduler.sv
// Round-robin front end for a free-running LFSR.  It reduces one captured
// sample modulo the granted requester's limit with a bit-serial restoring remainder.
module rng_scheduler #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 10
) (
   input logic           i_clk,
   input logic           i_reset,
   rng_scheduler_if.slave io_bus
);
   localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StReduce, StDone} state_e;

   state_e           r_state;
   logic [IW-1:0]    r_rr_ptr;
   logic [IW-1:0]    r_grant;
   logic [WIDTH-1:0] r_sample;
   logic [WIDTH-1:0] r_lim;
   logic [WIDTH:0]   r_rem;
   logic [CW-1:0]    r_bit_cnt;
   logic [N_REQ-1:0] r_ack;
   logic [WIDTH-1:0] r_rng_out;
   logic [WIDTH-1:0] r_prev;
   logic             r_eq;

   logic             w_found;
   logic [IW-1:0]    w_grant;
   logic [IW-1:0]    w_next_ptr;
   logic [WIDTH:0]   w_t;
   logic [WIDTH:0]   w_rem_next;

   // Scan from the highest offset down so the nearest set bit at or after rr_ptr wins.
   always_comb begin
      w_found = 1'b0;
      w_grant = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (io_bus.req[(int'(r_rr_ptr) + k) % N_REQ]) begin
            w_found = 1'b1;
            w_grant = IW'((int'(r_rr_ptr) + k) % N_REQ);
         end
      end
      w_next_ptr = (w_grant == IW'(N_REQ - 1)) ? '0 : w_grant + IW'(1);
   end

   always_comb begin
      w_t        = {r_rem[WIDTH-1:0], r_sample[r_bit_cnt]};
      w_rem_next = (w_t >= {1'b0, r_lim}) ? (w_t - {1'b0, r_lim}) : w_t;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state   <= StIdle;
         r_rr_ptr  <= '0;
         r_grant   <= '0;
         r_sample  <= '0;
         r_lim     <= '0;
         r_rem     <= '0;
         r_bit_cnt <= '0;
         r_ack     <= '0;
         r_rng_out <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_found) begin
                  r_grant   <= w_grant;
                  r_sample  <= io_bus.lfsr_value;
                  r_lim     <= io_bus.limit[int'(w_grant)*WIDTH +: WIDTH];
                  r_rem     <= '0;
                  r_bit_cnt <= CW'(WIDTH - 1);
                  r_rr_ptr  <= w_next_ptr;
                  r_state   <= StReduce;
               end
            end
            StReduce: begin
               r_rem <= w_rem_next;
               if (r_bit_cnt == '0) begin
                  // A zero limit means unbounded: hand back the raw sample.
                  r_rng_out <= (r_lim == '0) ? r_sample : w_rem_next[WIDTH-1:0];
                  r_ack     <= N_REQ'(1) << r_grant;
                  r_state   <= StDone;
               end else begin
                  r_bit_cnt <= r_bit_cnt - CW'(1);
               end
            end
            StDone: begin
               r_ack   <= '0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   // Two consecutive equal observations flag a halted or all-zero LFSR.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_prev <= '0;
         r_eq   <= 1'b0;
      end else begin
         r_prev <= io_bus.lfsr_value;
         r_eq   <= (io_bus.lfsr_value == r_prev);
      end
   end

   assign io_bus.ack        = r_ack;
   assign io_bus.rng_out    = r_rng_out;
   assign io_bus.busy       = (r_state != StIdle);
   assign io_bus.lfsr_stuck = r_eq && (io_bus.lfsr_value == r_prev);
endmodule

// File: tb/tb_rng_scheduler.sv
// Directed self-checking bench for rng_scheduler: latency, modulo results,
// round-robin order, capture isolation, reset abort and stuck detection.
module tb_rng_scheduler;
   localparam int unsigned N = 4;
   localparam int unsigned W = 10;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   rng_scheduler_if #(.N_REQ(N), .WIDTH(W)) bus ();

   rng_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .io_bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one request and waits (bounded) for the ack; drops req once ack is seen.
   task automatic run_op(input int idx, input logic [W-1:0] lim, input logic [W-1:0] samp,
                         input bit scramble, output int cyc, output logic [N-1:0] ackv,
                         output logic [W-1:0] rngv, output int busy_cnt);
      bus.limit[idx*W +: W] = lim;
      bus.lfsr_value        = samp;
      bus.req[idx]          = 1'b1;
      cyc      = 0;
      busy_cnt = 0;
      ackv     = '0;
      while (cyc < 30 && ackv == '0) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.busy) busy_cnt++;
         ackv = bus.ack;
         if (scramble) begin
            bus.lfsr_value        = W'($urandom);
            bus.limit[idx*W +: W] = W'($urandom);
         end
      end
      rngv         = bus.rng_out;
      bus.req[idx] = 1'b0;
   endtask

   task automatic test_reset();
      bus.req        = '0;
      bus.limit      = '0;
      bus.lfsr_value = '0;
      reset          = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (bus.ack !== 4'b0000 || bus.rng_out !== 10'd0 || bus.busy !== 1'b0 ||
          bus.lfsr_stuck !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: ack=%b rng=%0d busy=%b stuck=%b, want 0 0 0 0",
                  bus.ack, bus.rng_out, bus.busy, bus.lfsr_stuck);
      end
      reset = 1'b1;
   endtask

   task automatic test_stuck();
      bus.lfsr_value = '0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (bus.lfsr_stuck !== 1'b1) begin
         bad++;
         $display("FAIL stuck_hold: got=%b want=1", bus.lfsr_stuck);
      end
      for (int i = 1; i <= 3; i++) begin
         bus.lfsr_value = W'(i * 5);
         @(posedge clk);
         #1;
         total++;
         if (bus.lfsr_stuck !== 1'b0) begin
            bad++;
            $display("FAIL stuck_toggle%0d: got=%b want=0", i, bus.lfsr_stuck);
         end
      end
   endtask

   task automatic test_single();
      int cyc, bcnt;
      logic [N-1:0] a;
      logic [W-1:0] r;
      run_op(0, 10'd641, 10'd900, 1'b0, cyc, a, r, bcnt);
      total++;
      if (cyc !== 11 || a !== 4'b0001) begin
         bad++;
         $display("FAIL single_latency: cycles=%0d ack=%b, want 11 0001", cyc, a);
      end
      total++;
      if (r !== 10'd259) begin
         bad++;
         $display("FAIL single_value: got=%0d want=259", r);
      end
      total++;
      if (bcnt !== 11) begin
         bad++;
         $display("FAIL single_busy: busy cycles=%0d want=11", bcnt);
      end
      @(posedge clk);
      #1;
      total++;
      if (bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.rng_out !== 10'd259) begin
         bad++;
         $display("FAIL single_after: ack=%b busy=%b rng=%0d, want 0000 0 259",
                  bus.ack, bus.busy, bus.rng_out);
      end
   endtask

   task automatic test_boundary();
      int idx_t [5]           = '{0, 0, 0, 0, 2};
      logic [W-1:0] lim_t [5] = '{10'd0, 10'd1, 10'd1023, 10'd1000, 10'd7};
      logic [W-1:0] smp_t [5] = '{10'd1000, 10'd1023, 10'd1023, 10'd999, 10'd1000};
      logic [W-1:0] exp_t [5] = '{10'd1000, 10'd0, 10'd0, 10'd999, 10'd6};
      int cyc, bcnt;
      logic [N-1:0] a;
      logic [N-1:0] exp_ack;
      logic [W-1:0] r;
      for (int i = 0; i < 5; i++) begin
         run_op(idx_t[i], lim_t[i], smp_t[i], 1'b0, cyc, a, r, bcnt);
         exp_ack = N'(1) << idx_t[i];
         total++;
         if (cyc !== 11 || a !== exp_ack || r !== exp_t[i]) begin
            bad++;
            $display("FAIL boundary%0d: cycles=%0d ack=%b rng=%0d, want 11 %b %0d",
                     i, cyc, a, r, exp_ack, exp_t[i]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_capture();
      int cyc, bcnt;
      logic [N-1:0] a;
      logic [W-1:0] r;
      run_op(0, 10'd641, 10'd900, 1'b1, cyc, a, r, bcnt);
      total++;
      if (cyc !== 11 || a !== 4'b0001 || r !== 10'd259) begin
         bad++;
         $display("FAIL capture: cycles=%0d ack=%b rng=%0d, want 11 0001 259", cyc, a, r);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int cyc;
      bit seen;
      bus.limit[0 +: W] = 10'd641;
      bus.lfsr_value    = 10'd900;
      bus.req[0]        = 1'b1;
      repeat (6) @(posedge clk);  // sample edge plus five reduction edges
      #1;
      reset = 1'b0;
      #1;
      total++;
      if (bus.ack !== 4'b0000 || bus.rng_out !== 10'd0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: ack=%b rng=%0d busy=%b, want 0000 0 0",
                  bus.ack, bus.rng_out, bus.busy);
      end
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (bus.ack != '0) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL reset_mid_noack: ack pulsed during reset, want none");
      end
      bus.lfsr_value = 10'd1000;
      reset          = 1'b1;
      cyc            = 0;
      while (cyc < 30 && bus.ack == '0) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      total++;
      if (cyc !== 11 || bus.ack !== 4'b0001 || bus.rng_out !== 10'd359) begin
         bad++;
         $display("FAIL reset_mid_resume: cycles=%0d ack=%b rng=%0d, want 11 0001 359",
                  cyc, bus.ack, bus.rng_out);
      end
      bus.req[0] = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_seq [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
      int exp_cyc [4]           = '{11, 23, 35, 47};
      int cyc;
      int n;
      bit saw2;
      reset          = 1'b0;
      bus.limit      = {4{10'd641}};
      bus.lfsr_value = 10'd900;
      bus.req        = 4'b1011;
      @(posedge clk);
      #1;
      reset = 1'b1;
      cyc   = 0;
      n     = 0;
      saw2  = 1'b0;
      while (cyc < 60 && n < 4) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.ack[2]) saw2 = 1'b1;
         if (bus.ack != '0) begin
            total++;
            if (bus.ack !== exp_seq[n] || cyc !== exp_cyc[n]) begin
               bad++;
               $display("FAIL rr_ack%0d: ack=%b at %0d, want %b at %0d",
                        n, bus.ack, cyc, exp_seq[n], exp_cyc[n]);
            end
            n++;
         end
      end
      total++;
      if (n !== 4 || saw2) begin
         bad++;
         $display("FAIL rr_count: acks=%0d saw_req2=%b, want 4 0", n, saw2);
      end
      bus.req = '0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_stuck();
      test_single();
      test_boundary();
      test_capture();
      test_reset_mid();
      test_round_robin();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
